// File: rtl/inverter_tester_pkg.sv
// inverter_tester_pkg: shared state encoding and default sizing for the inverter loopback tester
package inverter_tester_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int DEF_DIV_W = 16;
   localparam int DEF_CNT_W = 16;
   localparam int DEF_LAT_W = 8;
   localparam int DEF_TIMEOUT = 255;
   localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/resp_sync.sv
// resp_sync: multi-flop single-bit synchronizer, cleared to 0 on reset
module resp_sync
   import inverter_tester_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;
   always_ff @(posedge clk)
      ff <= rst ? '0 : {ff[STAGES-2:0], d};
   assign q = ff[STAGES-1];
endmodule

// File: rtl/inverter_loopback_tester.sv
// inverter_loopback_tester: square-wave stimulus and loopback edge/latency checker for the double-inverter macro
module inverter_loopback_tester
   import inverter_tester_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int LAT_W = DEF_LAT_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] half_period,
   input  logic [CNT_W-1:0] num_cycles,
   output logic             stim_out,
   input  logic             resp_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] edge_count,
   output logic [CNT_W-1:0] mismatch_count,
   output logic [LAT_W-1:0] lat_max
);
   state_t state;
   logic resp_s, pending, expected, match, timeout, toggle, pend_n;
   logic [DIV_W-1:0] hp, div, hp_in;
   logic [CNT_W-1:0] nc;
   logic [CNT_W:0] tog;
   logic [LAT_W-1:0] lat, lat_inc;
   resp_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .rst(rst),
      .d(resp_in),
      .q(resp_s)
   );
   assign busy = state == RUN || state == DRAIN;
   assign done = state == DONE;
   // Resolution against the old expected level happens before a same-cycle toggle re-arms.
   always_comb begin
      hp_in = half_period == '0 ? DIV_W'(1) : half_period;
      lat_inc = lat + 1'b1;
      match = busy && pending && resp_s == expected;
      timeout = busy && pending && !match && lat_inc >= LAT_W'(TIMEOUT);
      toggle = state == RUN && div == DIV_W'(1);
      pend_n = pending && !match && !timeout;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         stim_out <= 1'b0;
         hp <= '0;
         div <= '0;
         nc <= '0;
         tog <= '0;
         pending <= 1'b0;
         expected <= 1'b0;
         lat <= '0;
         edge_count <= '0;
         mismatch_count <= '0;
         lat_max <= '0;
      end else if (start && !busy) begin
         state <= num_cycles == '0 ? DONE : RUN;
         stim_out <= 1'b0;
         hp <= hp_in;
         div <= hp_in;
         nc <= num_cycles;
         tog <= '0;
         pending <= 1'b0;
         lat <= '0;
         edge_count <= '0;
         mismatch_count <= '0;
         lat_max <= '0;
      end else if (busy) begin
         div <= toggle ? hp : div - 1'b1;
         if (match) begin
            edge_count <= edge_count + CNT_W'(~&edge_count);
            lat_max <= lat > lat_max ? lat : lat_max;
         end
         if (timeout || (toggle && pend_n))
            mismatch_count <= mismatch_count + CNT_W'(~&mismatch_count);
         if (toggle) begin
            stim_out <= ~stim_out;
            tog <= tog + 1'b1;
            pending <= 1'b1;
            expected <= ~stim_out;
            lat <= '0;
         end else begin
            pending <= pend_n;
            lat <= pend_n ? lat_inc : lat;
         end
         if (toggle && tog + 1'b1 == {nc, 1'b0})
            state <= DRAIN;
         else if (state == DRAIN && !pend_n)
            state <= DONE;
      end
   end
endmodule

// File: tb/tb_inverter_loopback_tester.sv
// tb_inverter_loopback_tester: directed vector and sequence checks of the inverter loopback tester
module tb_inverter_loopback_tester;
   logic clk = 1'b0;
   logic rst, start, stim_out, resp_in, busy, done;
   logic [15:0] half_period, num_cycles, edge_count, mismatch_count;
   logic [7:0] lat_max;
   logic [1:0] mode;
   logic [4:0] dly;
   int checks = 0;
   int fails = 0;
   typedef struct {
      logic [15:0] hp;
      logic [15:0] nc;
      logic [1:0]  mode;
      int          e;
      int          m;
      int          l;
      bit          b;
   } vec_t;
   vec_t v[6];
   always #5 clk = ~clk;
   always @(posedge clk) dly <= rst ? 5'd0 : {dly[3:0], stim_out};
   // mode 0: direct loopback, 1: response stuck low, 2: five-clock external delay
   assign resp_in = mode == 2'd0 ? stim_out : mode == 2'd2 ? dly[4] : 1'b0;
   inverter_loopback_tester dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .half_period(half_period),
      .num_cycles(num_cycles),
      .stim_out(stim_out),
      .resp_in(resp_in),
      .busy(busy),
      .done(done),
      .edge_count(edge_count),
      .mismatch_count(mismatch_count),
      .lat_max(lat_max)
   );
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
      checks++;
      if (a !== r) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", n, a, r);
      end
   endtask
   task automatic run(input vec_t x, output bit seen);
      @(negedge clk);
      half_period = x.hp;
      num_cycles = x.nc;
      mode = x.mode;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = busy;
      for (int i = 0; i < 4000 && !done; i++) begin
         @(negedge clk);
         seen |= busy;
      end
      chk("run_reaches_done", done, 1);
   endtask
   initial begin
      bit seen;
      logic prev;
      int nch;
      int ch[3];
      v[0] = '{16'd4, 16'd3, 2'd0, 6, 0, 2, 1'b1};
      v[1] = '{16'd300, 16'd1, 2'd1, 1, 1, 0, 1'b1};
      v[2] = '{16'd0, 16'd0, 2'd0, 0, 0, 0, 1'b0};
      v[3] = '{16'd10, 16'd2, 2'd2, 4, 0, 7, 1'b1};
      v[4] = '{16'd0, 16'd1, 2'd0, 1, 1, 0, 1'b1};
      v[5] = '{16'd3, 16'd2, 2'd0, 4, 0, 2, 1'b1};
      rst = 1'b1;
      start = 1'b0;
      half_period = '0;
      num_cycles = '0;
      mode = 2'd0;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_stim", stim_out, 0);
      chk("reset_edge", edge_count, 0);
      chk("reset_mismatch", mismatch_count, 0);
      chk("reset_lat_max", lat_max, 0);
      rst = 1'b0;
      foreach (v[i]) begin
         run(v[i], seen);
         chk($sformatf("vec%0d_busy_seen", i), seen, v[i].b);
         chk($sformatf("vec%0d_edge", i), edge_count, v[i].e);
         chk($sformatf("vec%0d_mismatch", i), mismatch_count, v[i].m);
         chk($sformatf("vec%0d_lat_max", i), lat_max, v[i].l);
         chk($sformatf("vec%0d_stim_end", i), stim_out, 0);
         chk($sformatf("vec%0d_busy_end", i), busy, 0);
      end
      // stimulus timing and start ignored while running
      @(negedge clk);
      half_period = 16'd4;
      num_cycles = 16'd3;
      mode = 2'd0;
      start = 1'b1;
      prev = 1'b0;
      nch = 0;
      for (int k = 1; k < 300; k++) begin
         @(negedge clk);
         start = (k == 10);
         if (k == 10) num_cycles = 16'd0;
         if (k == 1) chk("busy_cycle_after_start", busy, 1);
         if (k == 11) chk("busy_after_ignored_start", busy, 1);
         if (stim_out !== prev) begin
            if (nch < 3) ch[nch] = k;
            nch++;
            prev = stim_out;
         end
         if (done) break;
      end
      chk("seq_done", done, 1);
      chk("seq_toggles", nch, 6);
      chk("seq_first_rise", ch[0], 5);
      chk("seq_first_fall", ch[1], 9);
      chk("seq_second_rise", ch[2], 13);
      chk("seq_edge", edge_count, 6);
      chk("seq_mismatch", mismatch_count, 0);
      chk("seq_lat_max", lat_max, 2);
      repeat (5) @(negedge clk);
      chk("done_held", done, 1);
      chk("results_held", edge_count, 6);
      // reset in the middle of a run
      half_period = 16'd10;
      num_cycles = 16'd2;
      mode = 2'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      chk("midrun_busy", busy, 1);
      chk("midrun_edge", edge_count, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stim", stim_out, 0);
      chk("rst_edge", edge_count, 0);
      chk("rst_mismatch", mismatch_count, 0);
      chk("rst_lat_max", lat_max, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/inverter_loopback_tester.md
Name: inverter_loopback_tester

Overview:
- Digital stimulus/checker stage that sits directly upstream of the 3.3 V double-inverter analog macro.
- Generates a programmable square wave on `stim_out`, which drives the inverter input through the pad/level-shift path.
- Samples the inverter output, looped back externally onto a digital input, as `resp_in`.
- Counts matched edges, missed/late edges and worst-case response latency. The double inverter is non-inverting, so the expected response level equals the stimulus level.

Parameters:
- DIV_W, 16, width of the half-period divider.
- CNT_W, 16, width of `num_cycles`, `edge_count` and `mismatch_count`.
- LAT_W, 8, width of the latency counter and `lat_max`.
- TIMEOUT, 255, clocks allowed for a response before an edge is counted as a mismatch; must be < 2^LAT_W.
- SYNC_STAGES, 2, synchronizer depth on `resp_in`; minimum 2.

Ports:
- clk  input  1  system clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle run request.
- half_period  input  DIV_W  clocks per stimulus half-period; 0 is treated as 1.
- num_cycles  input  CNT_W  full stimulus periods to generate.
- stim_out  output  1  stimulus to the inverter input.
- resp_in  input  1  asynchronous looped-back inverter output.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE; held until the next accepted start or rst.
- edge_count  output  CNT_W  responses matched within TIMEOUT; saturating.
- mismatch_count  output  CNT_W  edges overwritten or timed out; saturating.
- lat_max  output  LAT_W  largest matched latency, in clocks.

Behaviour:
- Clock and reset: one clock (`clk`); synchronous active-high reset (`rst`).
- Reset: state=IDLE; `stim_out`, `busy`, `done`, `edge_count`, `mismatch_count` and `lat_max` all 0; synchronizer flops 0; pending=0.
- Synchronization: `resp_in` passes through SYNC_STAGES flops to produce `resp_s`. Only `resp_s` is used internally.
- start handling:
  - Accepted in IDLE or DONE; ignored while busy.
  - On accept: latch half_period (0→1) and num_cycles; clear all counts; `stim_out`=0; pending=0; load divider with half_period; `done`=0.
  - Next state is RUN, or DONE immediately if num_cycles=0.
- RUN:
  - Divider decrements each cycle. On reaching 1: toggle `stim_out`, reload divider, increment toggle count.
  - After 2*num_cycles toggles, go to DRAIN.
- Pending-edge tracking (RUN and DRAIN):
  - Every toggle sets pending=1, expected=new `stim_out`, lat=0.
  - Each cycle with pending=1 and `resp_s`==expected: `edge_count`++; `lat_max`=max(`lat_max`, lat); pending=0.
  - Each cycle with pending=1 and no match: lat++. If lat reaches TIMEOUT, `mismatch_count`++ and pending=0.
- Simultaneous events:
  - A match or timeout evaluated against the old expected level is resolved before a same-cycle toggle arms the new pending edge.
  - A toggle while pending is still unresolved (no match or timeout that cycle) increments `mismatch_count` (overwrite).
- DRAIN: no toggles. Exit to DONE once pending=0.
- DONE: `done`=1, `busy`=0, results held, `stim_out` holds its last value (0 after a full run).
- Saturation: counters saturate at all-ones; lat saturates at TIMEOUT.
- Reset mid-run: returns to the reset state within one clock; partial results are discarded.
- Ideal loopback latency (`resp_in`=`stim_out`): each matched edge records lat = SYNC_STAGES.

Decomposition:
- Package `inverter_tester_pkg` contains:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - default constants for DIV_W, CNT_W, LAT_W, TIMEOUT and SYNC_STAGES.
- Sub-module `resp_sync`: parameterised SYNC_STAGES-deep single-bit synchronizer, reset to 0.
- The top module holds the FSM, divider, pending/latency logic and counters.

Test Plan:
- Loopback `resp_in`=`stim_out`, half_period=4, num_cycles=3 → 6 toggles, `stim_out` period 8 clocks, `edge_count`=6, `mismatch_count`=0, `lat_max`=2, `done`=1; `busy` high from the cycle after start until DONE.
- `resp_in` tied 0, half_period=300, num_cycles=1 → rising edge times out after 255 clocks, falling edge matches at lat 0: `edge_count`=1, `mismatch_count`=1, `lat_max`=0.
- num_cycles=0 with start → DONE on the next clock, `busy` never asserted, all counts 0, `stim_out`=0.
- Loopback through a 5-clock external delay, half_period=10, num_cycles=2 → `edge_count`=4, `lat_max`=7, `mismatch_count`=0.
- start pulsed during RUN → ignored, counts unchanged; `rst` asserted mid-RUN → next clock state IDLE, all outputs 0.
- half_period=0, loopback, num_cycles=1 → treated as 1: `stim_out` toggles on consecutive cycles, `busy` ends in DRAIN. Check `edge_count`+`mismatch_count`=2 and no lockup.
